// File: rtl/uart_pkt_parser.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkt_parser
// Description : Frames uart_rx bytes into opcode/length headers and forwards
//               payload with tlast. Optional mid-packet idle timeout is
//               enabled by defining UART_PKT_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_pkt_parser #(
  parameter logic [7:0] OP_ECHO = 8'hEC,
  parameter logic [7:0] OP_ADD  = 8'hAD,
  parameter logic [7:0] OP_MUL  = 8'h88,
  parameter logic [7:0] OP_DIV  = 8'h99
`ifdef UART_PKT_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 2**20
`endif
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  output logic        hdr_valid_o,
  output logic [7:0]  opcode_o,
  output logic [15:0] len_o,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic        err_o,
  output logic [1:0]  err_code_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RSVD    = 3'd1,
    S_LEN_LO  = 3'd2,
    S_LEN_HI  = 3'd3,
    S_PAYLOAD = 3'd4
  } state_t;

  localparam logic [1:0] C_ERR_RSVD    = 2'd1;
  localparam logic [1:0] C_ERR_SHORT   = 2'd2;
  localparam logic [1:0] C_ERR_TIMEOUT = 2'd3;

  state_t      r_state;
  logic [7:0]  r_op_pend;
  logic [7:0]  r_opcode;
  logic [7:0]  r_len_lo;
  logic [15:0] r_len;
  logic [15:0] r_remaining;
  logic        r_hdr_valid;
  logic        r_err;
  logic [1:0]  r_err_code;

  logic        w_in_payload;
  logic        w_hs;
  logic        w_is_op;
  logic [15:0] w_len_full;
  logic        w_expired;

  assign w_in_payload = (r_state == S_PAYLOAD);
  // Payload bytes pass straight through, so upstream sees downstream's ready.
  assign s_axis_tready = w_in_payload ? m_axis_tready : 1'b1;
  assign w_hs          = s_axis_tvalid & s_axis_tready;
  assign w_is_op       = (s_axis_tdata == OP_ECHO) || (s_axis_tdata == OP_ADD) ||
                         (s_axis_tdata == OP_MUL)  || (s_axis_tdata == OP_DIV);
  assign w_len_full    = {s_axis_tdata, r_len_lo};

  assign m_axis_tdata  = s_axis_tdata;
  assign m_axis_tvalid = w_in_payload & s_axis_tvalid;
  assign m_axis_tlast  = w_in_payload & (r_remaining == 16'd1);

  assign hdr_valid_o   = r_hdr_valid;
  assign opcode_o      = r_opcode;
  assign len_o         = r_len;
  assign err_o         = r_err;
  assign err_code_o    = r_err_code;

`ifdef UART_PKT_TIMEOUT_EN
  localparam logic [20:0] C_TIMEOUT = 21'(TIMEOUT_CYCLES);

  logic [20:0] r_timer;

  assign w_expired = (r_state != S_IDLE) && (r_timer == C_TIMEOUT);

  // Only upstream silence counts; a byte held back by downstream backpressure
  // freezes the timer instead.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_timer <= 21'd0;
    end else if ((r_state == S_IDLE) || w_hs || w_expired) begin
      r_timer <= 21'd0;
    end else if (!s_axis_tvalid) begin
      r_timer <= r_timer + 21'd1;
    end
  end
`else
  assign w_expired = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state     <= S_IDLE;
      r_op_pend   <= 8'd0;
      r_opcode    <= 8'd0;
      r_len_lo    <= 8'd0;
      r_len       <= 16'd0;
      r_remaining <= 16'd0;
      r_hdr_valid <= 1'b0;
      r_err       <= 1'b0;
      r_err_code  <= 2'd0;
    end else begin
      r_hdr_valid <= 1'b0;
      r_err       <= 1'b0;
      if (w_hs) begin
        case (r_state)
          S_IDLE: begin
            if (w_is_op) begin
              r_op_pend <= s_axis_tdata;
              r_state   <= S_RSVD;
            end
          end
          S_RSVD: begin
            if (s_axis_tdata == 8'h00) begin
              r_state <= S_LEN_LO;
            end else begin
              r_err      <= 1'b1;
              r_err_code <= C_ERR_RSVD;
              r_state    <= S_IDLE;
            end
          end
          S_LEN_LO: begin
            r_len_lo <= s_axis_tdata;
            r_state  <= S_LEN_HI;
          end
          S_LEN_HI: begin
            if (w_len_full < 16'd4) begin
              r_err      <= 1'b1;
              r_err_code <= C_ERR_SHORT;
              r_state    <= S_IDLE;
            end else begin
              r_hdr_valid <= 1'b1;
              r_opcode    <= r_op_pend;
              r_len       <= w_len_full;
              if (w_len_full == 16'd4) begin
                r_state <= S_IDLE;
              end else begin
                r_remaining <= w_len_full - 16'd4;
                r_state     <= S_PAYLOAD;
              end
            end
          end
          S_PAYLOAD: begin
            r_remaining <= r_remaining - 16'd1;
            if (r_remaining == 16'd1) begin
              r_state <= S_IDLE;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end else if (w_expired) begin
        r_err       <= 1'b1;
        r_err_code  <= C_ERR_TIMEOUT;
        r_remaining <= 16'd0;
        r_state     <= S_IDLE;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_pkt_parser.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_pkt_parser
// Description : Self-checking bench for uart_pkt_parser: directed vector table,
//               hand-written corner sequences and random streams checked
//               against a stream-level reference model. Timeout section
//               follows UART_PKT_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_pkt_parser;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic [7:0]  s_axis_tdata = 8'h00;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic        hdr_valid_o;
  logic [7:0]  opcode_o;
  logic [15:0] len_o;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b1;
  logic        m_axis_tlast;
  logic        err_o;
  logic [1:0]  err_code_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_i = ~clk_i;

  uart_pkt_parser #(
    .OP_ECHO(8'hEC)
`ifdef UART_PKT_TIMEOUT_EN
    , .TIMEOUT_CYCLES(100)
`endif
  ) dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .hdr_valid_o  (hdr_valid_o),
    .opcode_o     (opcode_o),
    .len_o        (len_o),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast (m_axis_tlast),
    .err_o        (err_o),
    .err_code_o   (err_code_o)
  );

  // Observed and expected event streams: {opcode,len}, {tlast,data}, err code.
  logic [23:0] q_hdr[$];
  logic [8:0]  q_beat[$];
  logic [1:0]  q_err[$];
  logic [23:0] e_hdr[$];
  logic [8:0]  e_beat[$];
  logic [1:0]  e_err[$];

  always @(negedge clk_i) begin
    if (!reset_i) begin
      if (hdr_valid_o) q_hdr.push_back({opcode_o, len_o});
      if (m_axis_tvalid && m_axis_tready) q_beat.push_back({m_axis_tlast, m_axis_tdata});
      if (err_o) q_err.push_back(err_code_o);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit is_op(input logic [7:0] b);
    return (b == 8'hEC) || (b == 8'hAD) || (b == 8'h88) || (b == 8'h99);
  endfunction

  // Walks a whole byte stream and lists the events it must produce.
  function automatic void build_expect(input logic [7:0] s[$]);
    int i, n, len, cnt;
    e_hdr.delete(); e_beat.delete(); e_err.delete();
    i = 0;
    n = s.size();
    while (i < n) begin
      if (!is_op(s[i])) begin i++; continue; end
      if (i + 1 >= n) break;
      if (s[i+1] != 8'h00) begin e_err.push_back(2'd1); i += 2; continue; end
      if (i + 3 >= n) break;
      len = int'(s[i+2]) + 256 * int'(s[i+3]);
      if (len < 4) begin e_err.push_back(2'd2); i += 4; continue; end
      e_hdr.push_back({s[i], 16'(len)});
      cnt = len - 4;
      i += 4;
      for (int k = 0; k < cnt && i < n; k++) begin
        e_beat.push_back({(k == cnt - 1), s[i]});
        i++;
      end
    end
  endfunction

  task automatic compare_all(input string tag);
    check({tag, "_hdr_count"}, q_hdr.size(), e_hdr.size());
    for (int i = 0; i < q_hdr.size() && i < e_hdr.size(); i++)
      check({tag, "_hdr"}, q_hdr[i], e_hdr[i]);
    check({tag, "_beat_count"}, q_beat.size(), e_beat.size());
    for (int i = 0; i < q_beat.size() && i < e_beat.size(); i++)
      check({tag, "_beat"}, q_beat[i], e_beat[i]);
    check({tag, "_err_count"}, q_err.size(), e_err.size());
    for (int i = 0; i < q_err.size() && i < e_err.size(); i++)
      check({tag, "_err"}, q_err[i], e_err[i]);
    q_hdr.delete(); q_beat.delete(); q_err.delete();
  endtask

  // Entered and left at posedge+1; handshake decided by ready seen at negedge.
  task automatic send_byte(input logic [7:0] b, input bit rnd);
    int  cyc;
    bit  hs;
    if (rnd && $urandom_range(3) == 0) begin
      s_axis_tvalid = 1'b0;
      repeat ($urandom_range(3, 1)) begin @(posedge clk_i); #1; end
    end
    s_axis_tdata  = b;
    s_axis_tvalid = 1'b1;
    hs  = 1'b0;
    cyc = 0;
    while (!hs && cyc < 2000) begin
      if (rnd) m_axis_tready = ($urandom_range(3) != 0);
      @(negedge clk_i);
      hs = s_axis_tready;
      @(posedge clk_i); #1;
      cyc++;
    end
    s_axis_tvalid = 1'b0;
    if (!hs) begin
      n_tests++; n_fail++;
      $display("FAIL send_byte: byte %0h not accepted within 2000 cycles", b);
    end
  endtask

  task automatic send_stream(input logic [7:0] s[$], input bit rnd);
    foreach (s[i]) send_byte(s[i], rnd);
  endtask

  task automatic drain();
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    repeat (6) begin @(posedge clk_i); #1; end
  endtask

  typedef struct {
    int           nb;
    logic [127:0] bytes;
    int           e_nhdr;
    logic [7:0]   e_op;
    logic [15:0]  e_len;
    int           e_beats;
    logic [7:0]   e_last;
    int           e_nerr;
    logic [1:0]   e_code;
  } vec_t;

  initial begin : main
    vec_t       vt[7];
    logic [7:0] s[$];
    logic [7:0] ops[4];
    int         nlast, bad, found, at;
    logic [1:0] code;

    ops[0] = 8'hEC; ops[1] = 8'hAD; ops[2] = 8'h88; ops[3] = 8'h99;
    vt[0] = '{6,  128'hEC0006004869,                 1, 8'hEC, 16'd6,  2, 8'h69, 0, 2'd0};
    vt[1] = '{9,  128'h0048EC000700616263,           1, 8'hEC, 16'd7,  3, 8'h63, 0, 2'd0};
    vt[2] = '{14, 128'hAD01AD000C001112131415161718, 1, 8'hAD, 16'd12, 8, 8'h18, 1, 2'd1};
    vt[3] = '{4,  128'h88000300,                     0, 8'h00, 16'd0,  0, 8'h00, 1, 2'd2};
    vt[4] = '{4,  128'h99000400,                     1, 8'h99, 16'd4,  0, 8'h00, 0, 2'd0};
    vt[5] = '{5,  128'h880005007F,                   1, 8'h88, 16'd5,  1, 8'h7F, 0, 2'd0};
    vt[6] = '{7,  128'h99ECEC00050033,               1, 8'hEC, 16'd5,  1, 8'h33, 1, 2'd1};

    // Reset state, checked between clock edges.
    #12;
    check("rst_hdr_valid", hdr_valid_o, 0);
    check("rst_opcode", opcode_o, 0);
    check("rst_len", len_o, 0);
    check("rst_err", err_o, 0);
    check("rst_err_code", err_code_o, 0);
    check("rst_m_tvalid", m_axis_tvalid, 0);
    check("rst_m_tlast", m_axis_tlast, 0);
    check("rst_s_tready", s_axis_tready, 1);
    @(negedge clk_i); reset_i = 1'b0;
    @(posedge clk_i); #1;

    // Directed vector table.
    foreach (vt[v]) begin
      for (int k = 0; k < vt[v].nb; k++)
        send_byte(vt[v].bytes[8*(vt[v].nb-1-k) +: 8], 1'b0);
      drain();
      check($sformatf("vec%0d_nhdr", v), q_hdr.size(), vt[v].e_nhdr);
      if (vt[v].e_nhdr > 0 && q_hdr.size() > 0)
        check($sformatf("vec%0d_hdr", v), q_hdr[q_hdr.size()-1], {vt[v].e_op, vt[v].e_len});
      check($sformatf("vec%0d_beats", v), q_beat.size(), vt[v].e_beats);
      if (vt[v].e_beats > 0 && q_beat.size() > 0)
        check($sformatf("vec%0d_last", v), q_beat[q_beat.size()-1], {1'b1, vt[v].e_last});
      nlast = 0;
      foreach (q_beat[i]) nlast += int'(q_beat[i][8]);
      check($sformatf("vec%0d_tlast_count", v), nlast, (vt[v].e_beats > 0) ? 1 : 0);
      check($sformatf("vec%0d_nerr", v), q_err.size(), vt[v].e_nerr);
      if (vt[v].e_nerr > 0 && q_err.size() > 0)
        check($sformatf("vec%0d_code", v), q_err[0], vt[v].e_code);
      q_hdr.delete(); q_beat.delete(); q_err.delete();
    end

    // Backpressure mid-payload: upstream must stall, tlast held on the byte.
    s = '{8'hEC, 8'h00, 8'h06, 8'h00, 8'h48};
    send_stream(s, 1'b0);
    m_axis_tready = 1'b0;
    s_axis_tdata  = 8'h69;
    s_axis_tvalid = 1'b1;
    bad = 0;
    repeat (50) begin
      @(negedge clk_i);
      if (s_axis_tready !== 1'b0 || m_axis_tvalid !== 1'b1 || m_axis_tlast !== 1'b1) bad++;
    end
    check("bp_stall", bad, 0);
    @(posedge clk_i); #1;
    m_axis_tready = 1'b1;
    send_byte(8'h69, 1'b0);
    drain();
    s.push_back(8'h69);
    build_expect(s);
    compare_all("bp");

    // Asynchronous reset mid-packet; the partial packet must not resume.
    s = '{8'hEC, 8'h00, 8'h08, 8'h00, 8'hAA};
    send_stream(s, 1'b0);
    m_axis_tready = 1'b0;
    @(negedge clk_i); #2;
    reset_i = 1'b1;
    #1;
    check("arst_opcode", opcode_o, 0);
    check("arst_len", len_o, 0);
    check("arst_s_tready", s_axis_tready, 1);
    @(negedge clk_i); reset_i = 1'b0;
    @(posedge clk_i); #1;
    q_hdr.delete(); q_beat.delete(); q_err.delete();
    m_axis_tready = 1'b1;
    s = '{8'hEC, 8'h00, 8'h06, 8'h00, 8'h48, 8'h69};
    send_stream(s, 1'b0);
    drain();
    build_expect(s);
    compare_all("post_rst");

    // Mid-packet idle.
    s = '{8'hEC, 8'h00, 8'h06, 8'h00, 8'h48};
    send_stream(s, 1'b0);
    found = 0; at = 0; code = 2'd0;
`ifdef UART_PKT_TIMEOUT_EN
    for (int c = 0; c < 150 && found == 0; c++) begin
      @(negedge clk_i);
      if (err_o) begin found = 1; at = c; code = err_code_o; end
    end
    check("tmo_fired", found, 1);
    check("tmo_code", code, 3);
    check("tmo_window", (at >= 98 && at <= 103), 1);
    @(posedge clk_i); #1;
    drain();
    build_expect(s);
    e_err.push_back(2'd3);
    compare_all("tmo");
    s = '{8'hEC, 8'h00, 8'h06, 8'h00, 8'h48, 8'h69};
    send_stream(s, 1'b0);
    drain();
    build_expect(s);
    compare_all("tmo_next");
`else
    repeat (150) begin
      @(negedge clk_i);
      if (err_o) found++;
    end
    check("no_tmo_err", found, 0);
    @(posedge clk_i); #1;
    send_byte(8'h69, 1'b0);
    drain();
    s.push_back(8'h69);
    build_expect(s);
    compare_all("no_tmo");
`endif

    // Random streams with gaps, bad headers and random downstream ready.
    for (int r = 0; r < 20; r++) begin
      s.delete();
      for (int p = 0; p < 6; p++) begin
        int kind, len;
        logic [7:0] g;
        logic [7:0] op;
        repeat ($urandom_range(3)) begin
          g = 8'($urandom_range(255));
          s.push_back(is_op(g) ? 8'h00 : g);
        end
        op   = ops[$urandom_range(3)];
        kind = $urandom_range(9);
        if (kind == 0) begin
          s.push_back(op); s.push_back(8'($urandom_range(255, 1)));
        end else if (kind == 1) begin
          s.push_back(op); s.push_back(8'h00);
          s.push_back(8'($urandom_range(3))); s.push_back(8'h00);
        end else begin
          len = (kind == 9) ? 16'h0104 : $urandom_range(20, 4);
          s.push_back(op); s.push_back(8'h00);
          s.push_back(8'(len % 256)); s.push_back(8'(len / 256));
          for (int k = 0; k < len - 4; k++) s.push_back(8'($urandom_range(255)));
        end
      end
      send_stream(s, 1'b1);
      drain();
      build_expect(s);
      compare_all($sformatf("rnd%0d", r));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
